// File: rtl/register_dump_serializer.sv
// Register dump serializer: snapshots the register bank debug bus on i_start and streams it out MSB-first, one byte per transfer.
// Latency: the first byte is valid the cycle after i_start is sampled in IDLE. One byte per cycle while i_ready is held high.
// Backpressure: o_valid/o_data hold while i_ready is low. Optional trailing XOR checksum byte when REGDUMP_CHECKSUM_EN is defined.
module register_dump_serializer #(
   parameter int REGISTER_BANK_SIZE = 32,
   parameter int BUS_SIZE           = 32
) (
   input  logic                                   i_clk,
   input  logic                                   i_reset,
   input  logic                                   i_start,
   input  logic [REGISTER_BANK_SIZE*BUS_SIZE-1:0] i_bus_debug,
   output logic [7:0]                             o_data,
   output logic                                   o_valid,
   input  logic                                   i_ready,
   output logic                                   o_busy,
   output logic                                   o_done
);

   localparam int BYTES_PER_REG = BUS_SIZE / 8;
   localparam int SNAP_W        = REGISTER_BANK_SIZE * BUS_SIZE;
   localparam int RIDX_W        = (REGISTER_BANK_SIZE > 1) ? $clog2(REGISTER_BANK_SIZE) : 1;
   localparam int BIDX_W        = (BYTES_PER_REG > 1) ? $clog2(BYTES_PER_REG) : 1;
   localparam int OFF_W         = (SNAP_W > 1) ? $clog2(SNAP_W) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
`ifdef REGDUMP_CHECKSUM_EN
      ST_CSUM = 2'd3,
`endif
      ST_DONE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [SNAP_W-1:0]   snap_q, snap_d;
   logic [RIDX_W-1:0]   reg_idx_q, reg_idx_d;
   logic [BIDX_W-1:0]   byte_idx_q, byte_idx_d;
`ifdef REGDUMP_CHECKSUM_EN
   logic [7:0]          csum_q, csum_d;
`endif

   logic                xfer;
   logic                last_byte;
   logic                last_reg;
   logic [OFF_W-1:0]    reg_base;
   logic [OFF_W-1:0]    byte_off;
   logic [OFF_W-1:0]    bit_off;
   logic [7:0]          cur_byte;

   assign xfer      = o_valid && i_ready;
   assign last_byte = (byte_idx_q == BIDX_W'(BYTES_PER_REG - 1));
   assign last_reg  = (reg_idx_q == RIDX_W'(REGISTER_BANK_SIZE - 1));

   // Byte select: register base plus MSB-first byte offset inside the register
   always_comb begin
      reg_base = OFF_W'(int'(reg_idx_q) * BUS_SIZE);
      byte_off = OFF_W'((BYTES_PER_REG - 1 - int'(byte_idx_q)) * 8);
      bit_off  = reg_base + byte_off;
      cur_byte = snap_q[bit_off +: 8];
   end

   // State register and counters; reset aborts any dump in progress
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q    <= ST_IDLE;
         reg_idx_q  <= '0;
         byte_idx_q <= '0;
`ifdef REGDUMP_CHECKSUM_EN
         csum_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         reg_idx_q  <= reg_idx_d;
         byte_idx_q <= byte_idx_d;
`ifdef REGDUMP_CHECKSUM_EN
         csum_q     <= csum_d;
`endif
      end
   end

   // Snapshot buffer holds pure data, so it needs no reset
   always_ff @(posedge i_clk) begin
      snap_q <= snap_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (i_start) state_d = ST_SEND;
         ST_SEND: begin
            if (xfer && last_byte && last_reg) begin
`ifdef REGDUMP_CHECKSUM_EN
               state_d = ST_CSUM;
`else
               state_d = ST_DONE;
`endif
            end
         end
`ifdef REGDUMP_CHECKSUM_EN
         ST_CSUM: if (xfer) state_d = ST_DONE;
`endif
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath next values: capture on start, advance counters on each data transfer
   always_comb begin
      snap_d     = snap_q;
      reg_idx_d  = reg_idx_q;
      byte_idx_d = byte_idx_q;
`ifdef REGDUMP_CHECKSUM_EN
      csum_d     = csum_q;
`endif
      if (state_q == ST_IDLE && i_start) begin
         snap_d     = i_bus_debug;
         reg_idx_d  = '0;
         byte_idx_d = '0;
`ifdef REGDUMP_CHECKSUM_EN
         csum_d     = '0;
`endif
      end else if (state_q == ST_SEND && xfer) begin
`ifdef REGDUMP_CHECKSUM_EN
         csum_d = csum_q ^ cur_byte;
`endif
         if (last_byte) begin
            byte_idx_d = '0;
            reg_idx_d  = last_reg ? '0 : reg_idx_q + RIDX_W'(1);
         end else begin
            byte_idx_d = byte_idx_q + BIDX_W'(1);
         end
      end
   end

   // Outputs decoded from the current state only
   always_comb begin
      o_data  = 8'h00;
      o_valid = 1'b0;
      o_busy  = 1'b0;
      o_done  = 1'b0;
      unique case (state_q)
         ST_SEND: begin
            o_data  = cur_byte;
            o_valid = 1'b1;
            o_busy  = 1'b1;
         end
`ifdef REGDUMP_CHECKSUM_EN
         ST_CSUM: begin
            o_data  = csum_q;
            o_valid = 1'b1;
            o_busy  = 1'b1;
         end
`endif
         ST_DONE: begin
            o_done = 1'b1;
            o_busy = 1'b1;
         end
         default: begin
            o_data  = 8'h00;
         end
      endcase
   end

endmodule

// File: tb/tb_register_dump_serializer.sv
// Bench for register_dump_serializer: directed steps with random data and random backpressure,
// checked against a byte-list model of the dump built from the register values.
module tb_register_dump_serializer;

   localparam int N     = 32;
   localparam int W     = 32;
   localparam int NB    = W / 8;
   localparam int NDATA = N * NB;
`ifdef REGDUMP_CHECKSUM_EN
   localparam int NTOT  = NDATA + 1;
`else
   localparam int NTOT  = NDATA;
`endif

   logic           i_clk = 1'b0;
   logic           i_reset;
   logic           i_start;
   logic           i_ready;
   logic [N*W-1:0] i_bus_debug;
   logic [7:0]     o_data;
   logic           o_valid;
   logic           o_busy;
   logic           o_done;

   int total = 0;
   int bad   = 0;

   logic [W-1:0] regs [N];
   logic [7:0]   exp_q [$];

   register_dump_serializer #(.REGISTER_BANK_SIZE(N), .BUS_SIZE(W)) dut (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_start     (i_start),
      .i_bus_debug (i_bus_debug),
      .o_data      (o_data),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_busy      (o_busy),
      .o_done      (o_done)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic load_bus();
      for (int k = 0; k < N; k++) i_bus_debug[k*W +: W] = regs[k];
   endtask

   // Expected stream: registers in order, each register most significant byte first
   task automatic build_expected();
      logic [7:0] x;
      logic [7:0] b;
      x = 8'h00;
      exp_q.delete();
      for (int k = 0; k < N; k++) begin
         for (int j = 0; j < NB; j++) begin
            b = 8'((regs[k] >> (8 * (NB - 1 - j))) & 32'hFF);
            x = x ^ b;
            exp_q.push_back(b);
         end
      end
`ifdef REGDUMP_CHECKSUM_EN
      exp_q.push_back(x);
`endif
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_valid"}, 32'(o_valid), 32'd0);
      chk({tag, "_busy"},  32'(o_busy),  32'd0);
      chk({tag, "_done"},  32'(o_done),  32'd0);
      chk({tag, "_data"},  32'(o_data),  32'h00);
   endtask

   // One dump: rand_ready toggles backpressure, abort_at resets after that many transfers,
   // glitch_at rewrites the bus and pulses i_start after that many transfers
   task automatic run_dump(input bit rand_ready, input int abort_at, input int glitch_at);
      int         sent;
      int         cycles;
      bit         stall;
      logic [7:0] held;
      build_expected();
      load_bus();
      i_start = 1'b1;
      step();
      i_start = 1'b0;
      chk("first_valid_latency", 32'(o_valid), 32'd1);
      sent   = 0;
      cycles = 0;
      stall  = 1'b0;
      held   = 8'h00;
      while (sent < NTOT && cycles < 4000) begin
         if (stall) chk("hold_data", 32'(o_data), 32'(held));
         chk("valid_high", 32'(o_valid), 32'd1);
         chk("busy_high",  32'(o_busy),  32'd1);
         chk("no_early_done", 32'(o_done), 32'd0);
         if (sent == glitch_at) begin
            i_bus_debug = '1;
            i_start     = 1'b1;
         end else begin
            i_start = 1'b0;
         end
         i_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (o_valid && i_ready) begin
            chk($sformatf("byte%0d", sent), 32'(o_data), 32'(exp_q[sent]));
            sent++;
            stall = 1'b0;
         end else begin
            stall = 1'b1;
            held  = o_data;
         end
         step();
         cycles++;
         if (abort_at >= 0 && sent == abort_at) begin
            i_ready = 1'b0;
            i_reset = 1'b1;
            step();
            check_idle("abort");
            i_reset = 1'b0;
            step();
            check_idle("after_abort");
            return;
         end
      end
      i_start = 1'b0;
      chk("transfer_count", 32'(sent), 32'(NTOT));
      if (!rand_ready) chk("send_cycles", 32'(cycles), 32'(NTOT));
      chk("done_pulse", 32'(o_done),  32'd1);
      chk("done_valid", 32'(o_valid), 32'd0);
      chk("done_busy",  32'(o_busy),  32'd1);
      i_ready = 1'b0;
      step();
      check_idle("post_done");
      step();
      check_idle("no_second_dump");
   endtask

   initial begin
      i_reset     = 1'b1;
      i_start     = 1'b0;
      i_ready     = 1'b0;
      i_bus_debug = '0;
      step();
      step();
      check_idle("reset");
      i_reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         check_idle("idle");
      end

      // Byte ordering and back-to-back timing
      for (int k = 0; k < N; k++) regs[k] = '0;
      regs[1] = 32'hDEADBEEF;
      run_dump(1'b0, -1, -1);

      // Backpressure with reg k = k
      for (int k = 0; k < N; k++) regs[k] = W'(k);
      run_dump(1'b1, -1, -1);

      // Snapshot isolation and start while busy, random data
      for (int k = 0; k < N; k++) regs[k] = W'($urandom);
      regs[1] = 32'hDEADBEEF;
      run_dump(1'b1, -1, 20);

      // Reset mid-dump then a complete fresh dump
      for (int k = 0; k < N; k++) regs[k] = W'($urandom);
      run_dump(1'b0, 10, -1);
      for (int k = 0; k < N; k++) regs[k] = W'($urandom);
      run_dump(1'b1, -1, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/register_dump_serializer.md
Name: register_dump_serializer

Overview:
- Consumer of the register bank debug bus: the read-out end of the register-file debug interface.
- On a start request, snapshots the full register bank debug bus and streams it out one byte at a time over a valid/ready handshake.
- The byte stream feeds the debug UART transmitter.
- Lets the debug unit dump all architectural registers without stalling the pipeline.

Parameters:
- REGISTER_BANK_SIZE, 32, number of registers in the dumped bank.
- BUS_SIZE, 32, register width in bits; must be a multiple of 8.

Ports:
- i_clk  input  1  clock; all logic on rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_start  input  1  dump request; sampled only in IDLE.
- i_bus_debug  input  REGISTER_BANK_SIZE*BUS_SIZE  flattened register bank; register k occupies bits [k*BUS_SIZE +: BUS_SIZE].
- o_data  output  8  current output byte.
- o_valid  output  1  o_data valid.
- i_ready  input  1  downstream accepts byte when o_valid && i_ready.
- o_busy  output  1  high in any state other than IDLE.
- o_done  output  1  single-cycle pulse after the final byte is accepted.

Behaviour:
- Reset (synchronous, active-high):
  - State = IDLE.
  - o_valid=0, o_busy=0, o_done=0, o_data=8'h00.
  - Counters cleared.
  - Asserting reset mid-dump aborts the dump; the next cycle is IDLE with no o_done pulse.
- States are IDLE, SEND, DONE.
- IDLE:
  - If i_start=1, capture all of i_bus_debug into an internal snapshot buffer.
  - Clear reg_idx and byte_idx, then go to SEND.
  - Later changes to i_bus_debug have no effect on the dump in progress.
- SEND:
  - o_valid=1 and o_busy=1.
  - o_data = byte byte_idx of snapshot register reg_idx, MSB-first: byte 0 = bits [BUS_SIZE-1:BUS_SIZE-8].
- Latency: first byte is valid the cycle after i_start is sampled.
- Handshake:
  - A transfer happens on a cycle where o_valid && i_ready.
  - While o_valid && !i_ready, o_data and o_valid must hold stable.
  - o_valid never drops without a transfer, except on reset.
- Counters:
  - On each transfer, byte_idx increments.
  - At BUS_SIZE/8-1, byte_idx wraps to 0 and reg_idx increments.
  - The transfer of the last byte (reg_idx=REGISTER_BANK_SIZE-1, last byte_idx) moves to DONE.
- Total bytes per dump = REGISTER_BANK_SIZE*BUS_SIZE/8 (128 with defaults).
- DONE:
  - o_valid=0, o_done=1 for exactly one cycle, o_busy=1.
  - Then IDLE unconditionally.
- i_start is ignored in SEND and DONE; there is no queuing.
- i_start held high continuously starts a new dump on the first IDLE cycle after DONE.
- Back-to-back transfers are supported: one byte per cycle when i_ready is held high.
- A default dump therefore takes 128 SEND cycles plus 1 DONE cycle.
- Counter widths: reg_idx is $clog2(REGISTER_BANK_SIZE) bits; byte_idx is $clog2(BUS_SIZE/8) bits (min 1).

Optional Feature:
- Macro: REGDUMP_CHECKSUM_EN.
- Defined:
  - After the last register byte is accepted, the FSM enters state CSUM instead of DONE.
  - CSUM presents one extra byte with o_valid=1: the XOR of all bytes sent in this dump.
  - The running XOR is cleared at dump start and updated on each transfer.
  - The same handshake rules apply; CSUM goes to DONE on transfer.
  - Total bytes = data bytes + 1.
- Undefined: no CSUM state and no checksum logic; behaviour exactly as above.

Test Plan:
- Reset then idle:
  - Stimulus: hold i_reset 2 cycles, i_start=0, then idle.
  - Required: o_valid=0, o_busy=0, o_done=0, o_data=00 throughout.
- Byte ordering:
  - Stimulus: reg1=32'hDEADBEEF, others 0; i_start pulse; i_ready=1.
  - Required: bytes 4..7 = DE,AD,BE,EF; all other bytes 00.
  - Required: exactly 128 transfers on 128 consecutive cycles, o_valid rising the cycle after start, o_done one cycle after the 128th transfer.
- Backpressure:
  - Stimulus: reg k = k; toggle i_ready pseudo-randomly.
  - Required: o_data stable whenever o_valid && !i_ready.
  - Required: the sequence is 00,00,00,k for each k=0..31 in order.
- Snapshot isolation and start-while-busy:
  - Stimulus: start with reg1=0xDEADBEEF; change i_bus_debug to all-ones and pulse i_start during SEND.
  - Required: the dump still outputs the original values; no second dump starts.
- Reset mid-dump:
  - Stimulus: assert i_reset after 10 transfers.
  - Required: next cycle o_valid=0, o_busy=0; no o_done; a new i_start then produces a full 128-byte dump from reg0 byte0.
- Checksum (REGDUMP_CHECKSUM_EN defined):
  - Stimulus: reg1=0xDEADBEEF, others 0.
  - Required: 129 transfers, final byte 8'h22.
  - Stimulus: reg k = k.
  - Required: final byte 8'h00.
